// File: rtl/mul_seq_shared_if.sv
// Request/result and shared-adder signals of the sequential multiplier.
// The slave side is the multiplier; the master side is the requester plus the shared adder.
interface mul_seq_shared_if #(
    parameter int W = 8
);
    logic             start;
    logic             signed_i;
    logic [W-1:0]     a_i;
    logic [W-1:0]     b_i;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic [2*W-1:0]   sum_in_a;
    logic [2*W-1:0]   sum_in_b;
    logic             sum_cin;
    logic [2*W-1:0]   sum_out;

    modport slave (
        input  start, signed_i, a_i, b_i, sum_out,
        output busy, done, result, sum_in_a, sum_in_b, sum_cin
    );

    modport master (
        output start, signed_i, a_i, b_i, sum_out,
        input  busy, done, result, sum_in_a, sum_in_b, sum_cin
    );
endinterface

// File: rtl/mul_seq_shared.sv
// Sequential shift-add multiplier, unsigned or signed per operation. Every addition,
// including the bit-counter increment, is borrowed from one external shared 2W-bit adder.
module mul_seq_shared #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mul_seq_shared_if.slave   bus
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUM  = 2'd1;
    localparam logic [1:0] S_INC  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sgn_q, sgn_d;
    logic [CW-1:0]  ctr_q, ctr_d;
    logic [2*W-1:0] result_q, result_d;
    logic           done_q, done_d;

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] pp;
    logic [W-1:0]   b_tail;
    logic           is_msb;
    logic           sub_sign;
    logic           last;
    logic [2*W-1:0] sum_in_a, sum_in_b;
    logic           sum_cin;

    assign a_ext    = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    assign pp       = b_q[ctr_q] ? (a_ext << ctr_q) : '0;
    assign is_msb   = (ctr_q == CW'(W - 1));
    assign sub_sign = sgn_q && is_msb;
    // Two shifts instead of ctr+1 keep the "no private adder" property intact.
    assign b_tail   = (b_q >> ctr_q) >> 1;
    assign last     = is_msb || (b_tail == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        ctr_d    = ctr_q;
        result_d = result_q;
        done_d   = 1'b0;
        sum_in_a = '0;
        sum_in_b = '0;
        sum_cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a_i;
                    b_d      = bus.b_i;
                    sgn_d    = bus.signed_i;
                    result_d = '0;
                    ctr_d    = '0;
                    state_d  = S_SUM;
                end
            end
            S_SUM: begin
                // The sign bit of a signed multiplier carries negative weight: add ~pp + 1.
                sum_in_a = sub_sign ? ~pp : pp;
                sum_cin  = sub_sign;
                sum_in_b = result_q;
                result_d = bus.sum_out;
                if (last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_INC;
                end
            end
            S_INC: begin
                sum_in_a = {{(2*W-CW){1'b0}}, ctr_q};
                sum_in_b = {{(2*W-1){1'b0}}, 1'b1};
                ctr_d    = bus.sum_out[CW-1:0];
                state_d  = S_SUM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            ctr_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            ctr_q    <= ctr_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.sum_in_a = sum_in_a;
    assign bus.sum_in_b = sum_in_b;
    assign bus.sum_cin  = sum_cin;
endmodule

// File: doc/mul_seq_shared.md
# mul_seq_shared

Parametrised sequential shift-add multiplier for W-bit operands, unsigned or two's-complement signed, selectable per operation. It holds no adder of its own: every addition, including the bit-counter increment, goes through one external 2W-bit adder shared with other datapath blocks. It replaces the fixed 8-bit unsigned multiplier. New features are width parameter, signed mode, carry-in to the shared adder, early termination on exhausted multiplier bits, a result clear at start, and a done pulse.

## Interface
- W, 8, operand width (≥2). Result and adder width 2W. Counter width CW = $clog2(W).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Accepted only in IDLE.
- signed_i  in  1  1 = two's-complement operands. Latched at acceptance.
- a_i  in  W  multiplicand. Latched at acceptance.
- b_i  in  W  multiplier. Latched at acceptance.
- busy  out  1  high in SUM/INC. Equals (state != IDLE).
- done  out  1  registered one-cycle pulse: result final.
- result  out  2W  accumulator. Holds the product from done until the next acceptance.
- sum_in_a  out  2W  shared adder operand A.
- sum_in_b  out  2W  shared adder operand B.
- sum_cin  out  1  shared adder carry-in.
- sum_out  in  2W  combinational (sum_in_a + sum_in_b + sum_cin) mod 2^(2W), same cycle.

## Operation
- States: IDLE, SUM, INC. Registers: state, a_r (W), b_r (W), sgn_r, ctr (CW), result (2W), done.
- Reset values: state=IDLE, ctr=0, a_r=0, b_r=0, sgn_r=0, result=0, done=0.
- Reset outputs: busy=0, sum_in_a=0, sum_in_b=0, sum_cin=0.
- IDLE:
  - Adder ports all 0.
  - On start: latch a_i, b_i, signed_i; result←0; ctr←0; go to SUM.
- a_ext: a_r sign-extended to 2W when sgn_r=1, else zero-extended.
- SUM, k = ctr:
  - pp = b_r[k] ? (a_ext << k) : 0.
  - If sgn_r and k = W-1: drive sum_in_a = ~pp, sum_cin = 1 (subtract the sign-bit weight).
  - Otherwise: drive sum_in_a = pp, sum_cin = 0.
  - sum_in_b = result. result ← sum_out.
- SUM exit:
  - last = (k = W-1) or (b_r >> (k+1)) = 0.
  - last: go to IDLE, done ← 1.
  - Otherwise: go to INC.
- INC:
  - sum_in_a = ctr zero-extended to 2W, sum_in_b = 1, sum_cin = 0.
  - ctr ← sum_out[CW-1:0]. Go to SUM.
- Width rule: all arithmetic is modulo 2^(2W). The final result is the exact product, unsigned or signed per sgn_r.
- Signed mode with negative b: b_r[W-1] = 1, so early termination never skips the sign-bit subtraction.
- start while busy: ignored. Operands are not re-latched; in-flight operation unaffected.
- start in the done cycle (state IDLE): accepted normally. done still pulses for the previous operation.
- rst asserted mid-operation: immediate return to reset values, no done pulse. The next start behaves as after power-up.

## Timing
- Acceptance edge E0. SUM occupies the cycle after E0.
- m = index of highest set bit of b_r (m = 0 if b_r = 0).
- Busy cycles = 2m+1: m+1 SUM cycles and m INC cycles. Maximum 2W-1.
- done is high for exactly one cycle, the first IDLE cycle after the last SUM. busy=0 in that cycle.
- result changes only at SUM edges, at acceptance (cleared), and on reset. Intermediate values are visible while busy; they are not valid.
- Adder ports change only with state/ctr. The shared adder must be free whenever busy=1.

## Test plan
- W=8, unsigned, a=13, b=11 (m=3): busy 7 cycles. done pulse with result=143 (0x008F). Check the sum_in_* sequence for each SUM/INC cycle.
- W=8, unsigned, a=255, b=255: busy 15 cycles, result=65025 (0xFE01). Then a=200, b=0: busy 1 cycle, result=0 (clear verified).
- W=8, signed, a=-3 (0xFD), b=5: result=0xFFF1 (-15), busy 5 cycles. a=5, b=-3 (0xFD): result=0xFFF1, busy 15 cycles. During the final SUM: sum_cin=1 and sum_in_a=~(0x0005<<7).
- W=8, signed, a=-128, b=-128: result=0x4000. Unsigned, a=0x80, b=0x80: result=0x4000, busy 15 cycles.
- start pulsed repeatedly while busy with different operands: first product unchanged, one done only. Then start in the done cycle: the new operation begins next cycle.
- rst asserted in cycle 4 of a 15-cycle operation: busy, done, result, sum_in_* all 0 immediately, no done pulse. A following 7×9 operation returns 63.
- W=16 instance: a=0xFFFF, b=0xFFFF unsigned gives 0xFFFE0001 after 31 busy cycles. Signed gives 0x00000001.
